// File: rtl/shift_register_with_valid_ready_if.sv
// Handshake bundle for the valid/ready shift register: upstream push side and downstream pop side.
// Pure wiring, no latency of its own.
// Backpressure travels on in_rdy (to upstream) and out_rdy (from downstream).
interface shift_register_with_valid_ready_if #(
  parameter int width = 8
);
  logic             in_vld;
  logic [width-1:0] in_data;
  logic             in_rdy;
  logic             out_vld;
  logic [width-1:0] out_data;
  logic             out_rdy;

  // Producer/consumer view: drives the push side and the downstream ready.
  modport master (
    output in_vld, in_data, out_rdy,
    input  in_rdy, out_vld, out_data
  );

  // Pipeline view: accepts pushes and presents the last stage.
  modport slave (
    input  in_vld, in_data, out_rdy,
    output in_rdy, out_vld, out_data
  );
endinterface

// File: rtl/shift_register_with_valid_ready.sv
// Valid/ready shift register of `depth` stages with bubble collapsing, flush and occupancy count.
// Latency: a transfer accepted into an empty pipe appears at the output `depth` cycles later.
// Backpressure: in_rdy drops only when every stage is full and out_rdy is low (or during flush).
module shift_register_with_valid_ready #(
  parameter int width = 8,
  parameter int depth = 8  // legal range 2..64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  shift_register_with_valid_ready_if.slave bus,
  output logic [$clog2(depth+1)-1:0]   count
);

  localparam int cw = $clog2(depth + 1);

  logic [depth-1:0]            vld_q;
  logic [depth-1:0]            vld_d;
  logic [depth-1:0][width-1:0] data_q;
  logic [depth-1:0][width-1:0] data_d;
  logic [cw-1:0]               count_q;
  logic [cw-1:0]               count_d;
  logic [depth-1:0]            take;
  logic                        in_hs;
  logic                        out_hs;

  // Ready chain: a stage can take new contents when it is empty or its occupant moves on.
  always_comb begin
    logic chain;
    take = '0;
    chain = ~vld_q[depth-1] | bus.out_rdy;
    take[depth-1] = chain;
    for (int i = depth - 2; i >= 0; i--) begin
      chain = ~vld_q[i] | chain;
      take[i] = chain;
    end
  end

  assign bus.in_rdy   = take[0] & ~flush;
  assign in_hs        = bus.in_vld & bus.in_rdy;
  assign out_hs       = vld_q[depth-1] & bus.out_rdy;
  assign bus.out_vld  = vld_q[depth-1];
  assign bus.out_data = data_q[depth-1];
  assign count        = count_q;

  // Stage update: each taking stage copies its upstream neighbour; data moves only with a valid bit.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (take[0]) begin
      vld_d[0] = in_hs;
      if (in_hs) begin
        data_d[0] = bus.in_data;
      end
    end
    for (int i = 1; i < depth; i++) begin
      if (take[i]) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) begin
          data_d[i] = data_q[i-1];
        end
      end
    end
    if (flush) begin
      vld_d = '0;
    end
  end

  // Occupancy: +1 on push only, -1 on pop only; flush empties regardless of a same-cycle pop.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (in_hs && !out_hs) begin
      count_d = count_q + cw'(1);
    end else if (out_hs && !in_hs) begin
      count_d = count_q - cw'(1);
    end
  end

  // Control state: cleared asynchronously so the pipe empties the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      count_q <= count_d;
    end
  end

  // Payload registers carry no reset; their contents are meaningless while the valid bit is low.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule

// File: tb/tb_shift_register_with_valid_ready.sv
// Self-checking bench: directed scenarios plus random traffic against an item/position model.
// Each item advances one slot per cycle unless blocked by the item ahead; the oldest leaves on out_rdy.
// Handshakes are decided from model predictions, never from DUT outputs.
module tb_shift_register_with_valid_ready;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush;
  logic [CW-1:0] count;

  shift_register_with_valid_ready_if #(.width(WIDTH)) bus ();

  shift_register_with_valid_ready #(.width(WIDTH), .depth(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: items oldest-first with their stage position; acc_q is acceptance order for delivery checks.
  logic [WIDTH-1:0] m_dat[$];
  int               m_pos[$];
  logic [WIDTH-1:0] acc_q[$];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_dat.delete();
    m_pos.delete();
    acc_q.delete();
  endtask

  // One cycle: drive after the falling edge, check mid-low-phase, advance model at the rising edge.
  task automatic step(input logic fl, input logic iv, input logic [WIDTH-1:0] id,
                      input logic ordy, output logic accepted);
    logic exp_ir;
    logic exp_ov;
    logic in_hs;
    logic out_hs;
    int   lim;
    flush       = fl;
    bus.in_vld  = iv;
    bus.in_data = id;
    bus.out_rdy = ordy;
    #1;
    exp_ov = (m_pos.size() > 0) && (m_pos[0] == DEPTH - 1);
    exp_ir = ((m_dat.size() < DEPTH) || ordy) && !fl;
    check_val("count", 32'(count), 32'(m_dat.size()));
    check_val("in_rdy", 32'(bus.in_rdy), 32'(exp_ir));
    check_val("out_vld", 32'(bus.out_vld), 32'(exp_ov));
    if (exp_ov) check_val("out_data", 32'(bus.out_data), 32'(m_dat[0]));
    in_hs  = iv & exp_ir;
    out_hs = exp_ov & ordy;
    if (out_hs && acc_q.size() > 0) check_val("order", 32'(bus.out_data), 32'(acc_q.pop_front()));
    if (in_hs) acc_q.push_back(id);
    if (fl) acc_q.delete();
    @(posedge clk);
    if (fl) begin
      m_dat.delete();
      m_pos.delete();
    end else begin
      if (out_hs) begin
        void'(m_dat.pop_front());
        void'(m_pos.pop_front());
      end
      for (int k = 0; k < m_pos.size(); k++) begin
        lim = (k == 0) ? DEPTH - 1 : m_pos[k-1] - 1;
        m_pos[k] = (m_pos[k] + 1 < lim) ? m_pos[k] + 1 : lim;
      end
      if (in_hs) begin
        m_dat.push_back(id);
        m_pos.push_back(0);
      end
    end
    accepted = in_hs;
    @(negedge clk);
  endtask

  initial begin
    logic             acc;
    int               idx;
    int               pct;
    logic [WIDTH-1:0] a_list [5];

    flush       = 1'b0;
    bus.in_vld  = 1'b0;
    bus.in_data = '0;
    bus.out_rdy = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_val("rst_out_vld", 32'(bus.out_vld), 32'd0);
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_in_rdy", 32'(bus.in_rdy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single transfer: visible four cycles after acceptance, count 1 meanwhile.
    step(1'b0, 1'b1, 8'h11, 1'b1, acc);
    check_val("lat_acc", 32'(acc), 32'd1);
    for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 8'h00, 1'b1, acc);

    // Back-to-back stream with downstream always ready.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b1, acc);
      check_val("stream_acc", 32'(acc), 32'd1);
    end
    for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 8'h00, 1'b1, acc);
    check_val("stream_empty", 32'(count), 32'd0);

    // Fill against a stalled output, then release.
    a_list[0] = 8'hA1; a_list[1] = 8'hA2; a_list[2] = 8'hA3; a_list[3] = 8'hA4; a_list[4] = 8'hA5;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 1'b1, a_list[idx], 1'b0, acc);
      if (acc && idx < 4) idx++;
    end
    check_val("full_accepted", 32'(idx), 32'd4);
    check_val("full_count", 32'(count), 32'd4);
    for (int c = 0; c < 12; c++) begin
      if (idx < 5) begin
        step(1'b0, 1'b1, a_list[idx], 1'b1, acc);
        if (acc) idx++;
      end else begin
        step(1'b0, 1'b0, 8'h00, 1'b1, acc);
      end
    end
    check_val("full_drained", 32'(count), 32'd0);

    // Bubble collapse: B1 and B2 end up adjacent while stalled.
    step(1'b0, 1'b1, 8'hB1, 1'b0, acc);
    step(1'b0, 1'b0, 8'h00, 1'b0, acc);
    step(1'b0, 1'b0, 8'h00, 1'b0, acc);
    step(1'b0, 1'b1, 8'hB2, 1'b0, acc);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 8'h00, 1'b0, acc);
    check_val("bubble_count", 32'(count), 32'd2);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 8'h00, 1'b1, acc);

    // Flush of a full pipe with an offered input and stalled output.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, acc);
    check_val("flush_pre_count", 32'(count), 32'd4);
    step(1'b1, 1'b1, 8'hEE, 1'b0, acc);
    check_val("flush_no_accept", 32'(acc), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, acc);
    for (int c = 0; c < 5; c++) step(1'b0, 1'b0, 8'h00, 1'b1, acc);

    // Asynchronous reset between edges with three transfers held.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(8'hD0 + i), 1'b0, acc);
    check_val("arst_pre_count", 32'(count), 32'd3);
    #2 rst = 1'b1;
    #1;
    check_val("arst_out_vld", 32'(bus.out_vld), 32'd0);
    check_val("arst_count", 32'(count), 32'd0);
    check_val("arst_in_rdy", 32'(bus.in_rdy), 32'd1);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, 8'h5A, 1'b1, acc);
    check_val("arst_push", 32'(acc), 32'd1);
    for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 8'h00, 1'b1, acc);

    // Random traffic with varying downstream readiness.
    for (int c = 0; c < 3000; c++) begin
      case ((c / 250) % 3)
        0:       pct = 20;
        1:       pct = 55;
        default: pct = 90;
      endcase
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 8'($urandom),
           ($urandom_range(0, 99) < pct), acc);
    end
    for (int c = 0; c < 8; c++) step(1'b0, 1'b0, 8'h00, 1'b1, acc);
    check_val("final_empty", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
